// File: rtl/multi_rate_divider.sv
// Bank of independent programmable tick dividers. Each channel counts down a
// loaded period and emits a one-cycle tick, either periodically or once.
module multi_rate_divider #(
  parameter int WIDTH    = 28,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] rate_in,
  output logic [CHANNELS-1:0]       q,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state, state_next;
    logic [WIDTH-1:0] period_reg, count, count_next, rate;
    logic [CNT_W-1:0] ticks, ticks_next;
    logic             mode_lat, mode_next;
    logic             tick;

    assign rate = rate_in[i*WIDTH +: WIDTH];
    assign tick = (state == RUN) && enable[i] && (count == '0);

    assign q[i]                         = tick;
    assign busy[i]                      = (state == RUN);
    assign tick_count[i*CNT_W +: CNT_W] = ticks;

    // Reset also samples rate_in so a channel powers up with a usable period.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        state      <= IDLE;
        count      <= '0;
        ticks      <= '0;
        mode_lat   <= 1'b0;
        period_reg <= rate;
      end else begin
        state    <= state_next;
        count    <= count_next;
        ticks    <= ticks_next;
        mode_lat <= mode_next;
        if (load[i])
          period_reg <= rate;
      end
    end

    // A load landing on a periodic reload feeds the new rate straight into count.
    always_comb begin
      state_next = state;
      count_next = count;
      ticks_next = ticks;
      mode_next  = mode_lat;
      unique case (state)
        IDLE: begin
          if (enable[i]) begin
            count_next = period_reg;
            mode_next  = mode[i];
            ticks_next = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            ticks_next = ticks + CNT_W'(1);
            if (mode_lat)
              state_next = DONE;
            else
              count_next = load[i] ? rate : period_reg;
          end else if (enable[i]) begin
            count_next = count - WIDTH'(1);
          end
        end
        DONE: begin
          if (!enable[i])
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
